// File: rtl/adder_arbiter.sv
// adder_arbiter
//   Round-robin front end for one shared, pipelined adder. Up to N_REQ clients
//   post operand pairs; one winner per cycle is steered onto the add_* port
//   group. A tag pipeline of {valid, id} runs in lockstep with the adder, so
//   each sum comes back on a single valid/ready response channel with the
//   index of the client that issued it.
//
// Ports
//   clk, rst                 clock (rising edge), async active-low reset
//   req_valid/req_ready      per-client handshake; req_ready is one-hot or zero
//   req_a/req_b              packed operands, client i at [i*DATA_WIDTH +: DATA_WIDTH]
//   add_ebl/add_a/add_b      shared adder enable and operands
//   add_sum/add_carry        adder result from its last stage
//   rsp_valid/rsp_ready      response handshake
//   rsp_sum/rsp_carry/rsp_id result and originating client index
//   inflight                 registered count of valid tag stages
module adder_arbiter #(
  parameter int DATA_WIDTH = 16,
  parameter int N_REQ      = 4,
  parameter int LATENCY    = 2,
  parameter int ID_W       = $clog2(N_REQ)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [N_REQ-1:0]              req_valid,
  output logic [N_REQ-1:0]              req_ready,
  input  logic [N_REQ*DATA_WIDTH-1:0]   req_a,
  input  logic [N_REQ*DATA_WIDTH-1:0]   req_b,
  output logic                          add_ebl,
  output logic [DATA_WIDTH-1:0]         add_a,
  output logic [DATA_WIDTH-1:0]         add_b,
  input  logic [DATA_WIDTH-1:0]         add_sum,
  input  logic                          add_carry,
  output logic                          rsp_valid,
  input  logic                          rsp_ready,
  output logic [DATA_WIDTH-1:0]         rsp_sum,
  output logic                          rsp_carry,
  output logic [ID_W-1:0]               rsp_id,
  output logic [$clog2(LATENCY+1)-1:0]  inflight
);

  localparam int CNT_W = $clog2(LATENCY+1);

  // Tag pipeline: valid shift register plus matching id stages.
  logic [LATENCY-1:0]  vld_q;
  logic [ID_W-1:0]     id_q [LATENCY];
  logic [ID_W-1:0]     ptr_q, ptr_d;
  logic [CNT_W-1:0]    inflight_q, inflight_d;

  logic                gnt_any;
  logic [ID_W-1:0]     gid;
  logic                issue;

  // A held response freezes adder and tags together; a bubble never stalls.
  always_comb add_ebl = !(vld_q[LATENCY-1] && !rsp_ready);

  // Rotating priority search starting at ptr_q, wrapping modulo N_REQ.
  always_comb begin
    int idx;
    idx     = 0;
    gnt_any = 1'b0;
    gid     = '0;
    for (int off = 0; off < N_REQ; off++) begin
      idx = int'(ptr_q) + off;
      if (idx >= N_REQ) idx = idx - N_REQ;
      if (!gnt_any && req_valid[idx]) begin
        gnt_any = 1'b1;
        gid     = ID_W'(idx);
      end
    end
  end

  // Reset gates the grant so nothing is accepted while rst is low.
  always_comb issue = gnt_any && add_ebl && rst;

  always_comb begin
    req_ready = '0;
    add_a     = '0;
    add_b     = '0;
    if (issue) begin
      req_ready[gid] = 1'b1;
      add_a          = req_a[gid*DATA_WIDTH +: DATA_WIDTH];
      add_b          = req_b[gid*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  always_comb ptr_d = (gid == ID_W'(N_REQ-1)) ? '0 : gid + 1'b1;

  // Occupancy after this edge: the new issue plus every stage that is not
  // about to fall off the end.
  always_comb begin
    inflight_d = CNT_W'(issue);
    for (int k = 0; k < LATENCY-1; k++)
      inflight_d = inflight_d + CNT_W'(vld_q[k]);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld_q      <= '0;
      for (int k = 0; k < LATENCY; k++) id_q[k] <= '0;
      ptr_q      <= '0;
      inflight_q <= '0;
    end else if (add_ebl) begin
      vld_q[0] <= issue;
      id_q[0]  <= gid;
      for (int k = 1; k < LATENCY; k++) begin
        vld_q[k] <= vld_q[k-1];
        id_q[k]  <= id_q[k-1];
      end
      inflight_q <= inflight_d;
      if (issue) ptr_q <= ptr_d;
    end
  end

  always_comb begin
    rsp_valid = vld_q[LATENCY-1];
    rsp_id    = id_q[LATENCY-1];
    rsp_sum   = add_sum;
    rsp_carry = add_carry;
    inflight  = inflight_q;
  end

endmodule

// File: doc/adder_arbiter.md
Name: adder_arbiter

Overview:
- Shares one pipelined N-bit adder among N_REQ requesters using round-robin arbitration.
- Drives the adder's enable, operands and captured result through a port group named add_*.
- Tracks the requester ID of every in-flight operation and returns each result on one response channel with valid/ready backpressure.
- Sits between the attention-datapath clients and the shared adder instance.

Parameters:
- DATA_WIDTH, 16: operand and sum width.
- N_REQ, 4: number of requesters, 2..16.
- LATENCY, 2: adder latency in enabled clock edges, from operand capture to sum valid; at least 1.
- ID_W, $clog2(N_REQ): width of the response ID.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- req_valid  in  N_REQ  per-requester request valid.
- req_ready  out  N_REQ  per-requester grant/accept, one-hot or zero.
- req_a  in  N_REQ*DATA_WIDTH  operand A, packed, requester i at [i*DATA_WIDTH +: DATA_WIDTH].
- req_b  in  N_REQ*DATA_WIDTH  operand B, packed the same way.
- add_ebl  out  1  shared adder enable.
- add_a  out  DATA_WIDTH  adder operand A.
- add_b  out  DATA_WIDTH  adder operand B.
- add_sum  in  DATA_WIDTH  adder sum.
- add_carry  in  1  adder carry out.
- rsp_valid  out  1  result valid.
- rsp_ready  in  1  consumer accepts the result.
- rsp_sum  out  DATA_WIDTH  result sum.
- rsp_carry  out  1  result carry.
- rsp_id  out  ID_W  index of the requester that issued the result.
- inflight  out  $clog2(LATENCY+1)  number of valid tag stages.

Behaviour:
- Reset (rst=0, asynchronous):
  - All tag stages are invalid; the round-robin pointer is 0.
  - Outputs: rsp_valid=0, rsp_id=0, inflight=0, req_ready=0.
  - add_ebl=1, because no stage is valid.
  - Reset mid-operation discards all in-flight results; none is ever reported.
- Tag pipeline:
  - LATENCY stages of {v, id}; stage 0 loads {issue, grant_id}, and stage k loads stage k-1.
  - The pipeline advances only on edges where add_ebl=1, in lockstep with the adder.
- Response channel (combinational from the last stage):
  - rsp_valid = tag[LATENCY-1].v; rsp_id = tag[LATENCY-1].id.
  - rsp_sum = add_sum; rsp_carry = add_carry.
- Stall: add_ebl = !(rsp_valid && !rsp_ready).
  - A stall freezes the adder and the tags, so the response stays stable until accepted.
  - A bubble in the last stage never stalls, even when rsp_ready=0.
- Arbitration (combinational):
  - Search req_valid starting at pointer ptr, wrapping modulo N_REQ; the first set bit wins.
  - A grant is issued only when add_ebl=1.
  - req_ready[w]=1 for the winner only; a transfer occurs when req_valid[w] && req_ready[w].
- Operand mux:
  - add_a = req_a[w] and add_b = req_b[w] when granted; otherwise 0.
  - The adder captures the operands on the same edge the tag enters stage 0.
- Pointer update: on a transfer to w, ptr <= (w+1) mod N_REQ. With no transfer, ptr holds.
- Throughput: one issue per cycle when not stalled. A requester held valid waits at most N_REQ-1 grants.
- Latency: a transfer at edge T gives rsp_valid=1 after LATENCY enabled edges, counting T as the first.
- Simultaneous events: accept at the last stage and a new issue in the same cycle are both allowed (full throughput).
- inflight: registered count of valid tag stages, updated with the pipeline. Range 0..LATENCY.
- Requests: a requester may drop req_valid before it is granted; nothing is lost. Operands must be stable only in the granted cycle.

Test Plan:
1. Single request, LATENCY=2: req0 a=0x0003 b=0x0004, rsp_ready=1 -> rsp_valid two cycles after the grant with sum=0x0007, carry=0, id=0; inflight goes 1,1,0.
2. Overflow: a=0xFFFF b=0x0001 from req2 -> rsp_sum=0x0000, rsp_carry=1, rsp_id=2.
3. All four requesters held valid for 8 cycles, rsp_ready=1 -> grant order 0,1,2,3,0,1,2,3; rsp_id matches that order; a response every cycle after fill.
4. Backpressure: rsp_ready=0 for 5 cycles with the pipeline full -> add_ebl=0, req_ready=0, rsp fields stable. After release, all results arrive in order with none lost or duplicated.
5. Bubble: one request, then rsp_ready=0 before it reaches the last stage -> no stall until rsp_valid=1; new grants continue meanwhile.
6. Reset mid-flight: two operations in flight, pulse rst low -> rsp_valid=0, inflight=0, ptr=0 immediately. After release, the first grant with all requesters valid goes to requester 0.
